// File: rtl/jam_param_if.sv
// rtl/jam_param_if.sv - Control, result and cost-memory signals of jam_param
//
// Signals (slave = the jam_param search engine, master = host + cost memory):
//   START      host -> engine  single-cycle search request
//   W, J       engine -> mem   worker / job index of the cost being fetched
//   Cost       mem -> engine   cost of (W,J), one cycle after W/J
//   MinCost    engine -> host  minimum total assignment cost
//   MatchCount engine -> host  number of permutations achieving MinCost
//   Busy       engine -> host  search in progress
//   Valid      engine -> host  one-cycle pulse, results final
//   BestPerm   engine -> host  present only with JAM_BEST_PERM_EN defined
interface jam_param_if #(
  parameter int N  = 8,
  parameter int CW = 7
);
  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam int SW = CW + 3;

  logic          START;
  logic [IW-1:0] W;
  logic [IW-1:0] J;
  logic [CW-1:0] Cost;
  logic [SW-1:0] MinCost;
  logic [15:0]   MatchCount;
  logic          Busy;
  logic          Valid;
`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] BestPerm;

  modport slave (
    input  START, Cost,
    output W, J, MinCost, MatchCount, Busy, Valid, BestPerm
  );
  modport master (
    output START, Cost,
    input  W, J, MinCost, MatchCount, Busy, Valid, BestPerm
  );
`else
  modport slave (
    input  START, Cost,
    output W, J, MinCost, MatchCount, Busy, Valid
  );
  modport master (
    output START, Cost,
    input  W, J, MinCost, MatchCount, Busy, Valid
  );
`endif
endinterface

// File: rtl/jam_param.sv
// rtl/jam_param.sv - Exhaustive assignment search over all N! permutations
//
// Ports:
//   CLK    single clock, all state on the rising edge
//   RST_N  asynchronous active-low reset
//   bus    jam_param_if.slave: START, W, J, Cost, MinCost, MatchCount,
//          Busy, Valid (and BestPerm when JAM_BEST_PERM_EN is defined)
//
// Each permutation costs N FETCH cycles plus one NEXT cycle; the last Cost
// of a permutation arrives during NEXT and is folded into the comparison
// there, while the next permutation is computed combinationally.
module jam_param #(
  parameter int N  = 8,
  parameter int CW = 7
) (
  input  logic        CLK,
  input  logic        RST_N,
  jam_param_if.slave  bus
);
  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam int SW = CW + 3;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_NEXT, S_DONE} state_e;
  typedef logic [IW-1:0] idx_t;

  state_e        state_q, state_d;
  idx_t          idx_q, idx_d;
  idx_t          perm_q [N];
  idx_t          perm_d [N];
  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] min_q, min_d;
  logic [15:0]   cnt_q, cnt_d;
`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] best_q, best_d;
`endif

  logic [SW-1:0] total;
  logic          has_next;
  idx_t          perm_nxt [N];

  // Running sum including the Cost returned this cycle.
  assign total = sum_q + SW'(bus.Cost);

  // Lexicographic successor: pivot k is the rightmost ascent, l the rightmost
  // element above the pivot; swap them and reverse the suffix after k.
  always_comb begin : next_perm
    int   k;
    int   l;
    idx_t pivot_val;
    idx_t succ_val;
    idx_t swapped [N];
    has_next = 1'b0;
    k = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        has_next = 1'b1;
        k = i;
      end
    end
    pivot_val = '0;
    for (int i = 0; i < N; i++) if (i == k) pivot_val = perm_q[i];
    l = 0;
    for (int i = 0; i < N; i++) if (i > k && perm_q[i] > pivot_val) l = i;
    succ_val = '0;
    for (int i = 0; i < N; i++) if (i == l) succ_val = perm_q[i];
    for (int i = 0; i < N; i++) begin
      swapped[i] = perm_q[i];
      if (i == k) swapped[i] = succ_val;
      if (i == l) swapped[i] = pivot_val;
    end
    for (int i = 0; i < N; i++) begin
      perm_nxt[i] = swapped[i];
      for (int j = 0; j < N; j++) begin
        if (i > k && j == N + k - i) perm_nxt[i] = swapped[j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    perm_d  = perm_q;
    sum_d   = sum_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
`ifdef JAM_BEST_PERM_EN
    best_d  = best_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_FETCH;
          idx_d   = '0;
          sum_d   = '0;
          min_d   = '1;
          cnt_d   = '0;
          for (int i = 0; i < N; i++) perm_d[i] = idx_t'(i);
        end
      end
      S_FETCH: begin
        // Cost seen at idx 0 belongs to nothing; later ones to idx-1.
        sum_d = (idx_q == '0) ? '0 : total;
        if (idx_q == idx_t'(N - 1)) state_d = S_NEXT;
        else                        idx_d   = idx_q + idx_t'(1);
      end
      S_NEXT: begin
        if (total < min_q) begin
          min_d = total;
          cnt_d = 16'd1;
`ifdef JAM_BEST_PERM_EN
          for (int i = 0; i < N; i++) best_d[i*IW +: IW] = perm_q[i];
`endif
        end else if (total == min_q && cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        idx_d = '0;
        if (has_next) begin
          perm_d  = perm_nxt;
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) perm_q[i] <= idx_t'(i);
`ifdef JAM_BEST_PERM_EN
      best_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      perm_q  <= perm_d;
`ifdef JAM_BEST_PERM_EN
      best_q  <= best_d;
`endif
    end
  end

  assign bus.W          = (state_q == S_FETCH) ? idx_q : '0;
  assign bus.J          = (state_q == S_FETCH) ? perm_q[idx_q] : '0;
  assign bus.MinCost    = min_q;
  assign bus.MatchCount = cnt_q;
  assign bus.Busy       = (state_q == S_FETCH) || (state_q == S_NEXT);
  assign bus.Valid      = (state_q == S_DONE);
`ifdef JAM_BEST_PERM_EN
  assign bus.BestPerm   = best_q;
`endif
endmodule
